// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths,
// control-bundle bit positions and the control payload layout.
package id_ex_stage_reg_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam int unsigned WB_W     = 2;
  localparam int unsigned M_W      = 3;
  localparam int unsigned EX_W     = 2;
  localparam int unsigned ALU_OP_W = 2;

  localparam int unsigned M_MEM_READ = 1;

  // Control bundles keep Control_unit's ascending bit numbering.
  typedef struct packed {
    logic [0:WB_W-1]     wb;
    logic [0:M_W-1]      m;
    logic [0:EX_W-1]     ex;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  function automatic logic is_load(input logic [0:M_W-1] m);
    return m[M_MEM_READ];
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Bus between decode, the ID/EX register and the EX stage.
interface id_ex_stage_reg_if
  import id_ex_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);
  logic [0:WB_W-1]     id_WB;
  logic [0:M_W-1]      id_M;
  logic [0:EX_W-1]     id_EX;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic                id_valid;
  logic [DATA_W-1:0]   id_pc_plus4;
  logic [DATA_W-1:0]   id_rd1;
  logic [DATA_W-1:0]   id_rd2;
  logic [DATA_W-1:0]   id_imm;
  logic [REG_AW-1:0]   id_rs;
  logic [REG_AW-1:0]   id_rt;
  logic [REG_AW-1:0]   id_rd;
  logic                flush_i;
  logic                hold_i;

  logic [0:WB_W-1]     ex_WB;
  logic [0:M_W-1]      ex_M;
  logic [0:EX_W-1]     ex_EX;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic                ex_valid;
  logic [DATA_W-1:0]   ex_pc_plus4;
  logic [DATA_W-1:0]   ex_rd1;
  logic [DATA_W-1:0]   ex_rd2;
  logic [DATA_W-1:0]   ex_imm;
  logic [REG_AW-1:0]   ex_rs;
  logic [REG_AW-1:0]   ex_rt;
  logic [REG_AW-1:0]   ex_rd;
  logic                stall_o;
  logic [CNT_W-1:0]    bubble_cnt;

  modport master (
    output id_WB, id_M, id_EX, id_alu_op, id_valid, id_pc_plus4,
           id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, flush_i, hold_i,
    input  ex_WB, ex_M, ex_EX, ex_alu_op, ex_valid, ex_pc_plus4,
           ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, stall_o, bubble_cnt
  );

  modport slave (
    input  id_WB, id_M, id_EX, id_alu_op, id_valid, id_pc_plus4,
           id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, flush_i, hold_i,
    output ex_WB, ex_M, ex_EX, ex_alu_op, ex_valid, ex_pc_plus4,
           ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, stall_o, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
module id_ex_stage_reg_hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  output logic              hazard_c
);
  // $zero is hard-wired, so a load targeting it is never a real dependency.
  assign hazard_c = ex_valid_i & ex_mem_read_i & id_valid_i
                  & (ex_rt_i != '0)
                  & ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble insertion on load-use hazards and
// branch flush, hold while EX is busy, and a saturating bubble counter.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  id_ex_stage_reg_if.slave  bus
);

  typedef struct packed {
    ctrl_t             ctrl;
    logic              valid;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } stage_t;

  stage_t           stage_q, stage_d, id_stage_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard_c;
  logic             ex_load_c;
  logic             bubble_c;

  assign id_stage_c = {bus.id_WB, bus.id_M, bus.id_EX, bus.id_alu_op, bus.id_valid,
                       bus.id_pc_plus4, bus.id_rd1, bus.id_rd2, bus.id_imm,
                       bus.id_rs, bus.id_rt, bus.id_rd};

  assign ex_load_c = is_load(stage_q.ctrl.m);

  id_ex_stage_reg_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid_i    (stage_q.valid),
    .ex_mem_read_i (ex_load_c),
    .ex_rt_i       (stage_q.rt),
    .id_valid_i    (bus.id_valid),
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .hazard_c      (hazard_c)
  );

  // A taken branch redirects the PC, so it must never be frozen by a stall.
  assign bus.stall_o = (hazard_c | bus.hold_i) & ~bus.flush_i;

  // Priority: flush, then hold, then hazard, then normal advance.
  always_comb begin
    stage_d  = stage_q;
    cnt_d    = cnt_q;
    bubble_c = 1'b0;
    if (bus.flush_i) begin
      bubble_c = 1'b1;
    end else if (bus.hold_i) begin
      bubble_c = 1'b0;
    end else if (hazard_c) begin
      bubble_c = 1'b1;
    end else begin
      stage_d = id_stage_c;
    end
    if (bubble_c) begin
      stage_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ex_WB       = stage_q.ctrl.wb;
  assign bus.ex_M        = stage_q.ctrl.m;
  assign bus.ex_EX       = stage_q.ctrl.ex;
  assign bus.ex_alu_op   = stage_q.ctrl.alu_op;
  assign bus.ex_valid    = stage_q.valid;
  assign bus.ex_pc_plus4 = stage_q.pc_plus4;
  assign bus.ex_rd1      = stage_q.rd1;
  assign bus.ex_rd2      = stage_q.rd2;
  assign bus.ex_imm      = stage_q.imm;
  assign bus.ex_rs       = stage_q.rs;
  assign bus.ex_rt       = stage_q.rt;
  assign bus.ex_rd       = stage_q.rd;
  assign bus.bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed and random checks of id_ex_stage_reg against a cycle-level model.
module tb_id_ex_stage_reg;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [0:1]    wb;
    logic [0:2]    m;
    logic [0:1]    ex;
    logic [1:0]    alu;
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
  } stage_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  stage_t in_s, exp_s;
  int     exp_cnt;
  logic   flush, hold;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();

  id_ex_stage_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    bus.id_WB       = in_s.wb;
    bus.id_M        = in_s.m;
    bus.id_EX       = in_s.ex;
    bus.id_alu_op   = in_s.alu;
    bus.id_valid    = in_s.valid;
    bus.id_pc_plus4 = in_s.pc;
    bus.id_rd1      = in_s.rd1;
    bus.id_rd2      = in_s.rd2;
    bus.id_imm      = in_s.imm;
    bus.id_rs       = in_s.rs;
    bus.id_rt       = in_s.rt;
    bus.id_rd       = in_s.rd;
    bus.flush_i     = flush;
    bus.hold_i      = hold;
  endtask

  function automatic stage_t observed();
    return {bus.ex_WB, bus.ex_M, bus.ex_EX, bus.ex_alu_op, bus.ex_valid,
            bus.ex_pc_plus4, bus.ex_rd1, bus.ex_rd2, bus.ex_imm,
            bus.ex_rs, bus.ex_rt, bus.ex_rd};
  endfunction

  // A load sitting in EX whose destination the ID instruction reads.
  function automatic logic model_hazard();
    return exp_s.valid && exp_s.m[1] && in_s.valid && (exp_s.rt != 0)
        && ((exp_s.rt == in_s.rs) || (exp_s.rt == in_s.rt));
  endfunction

  function automatic stage_t rand_instr();
    stage_t s;
    s.wb    = 2'($urandom);
    s.m     = ($urandom_range(2) == 0) ? 3'b010 : (3'($urandom) & 3'b101);
    s.ex    = 2'($urandom);
    s.alu   = 2'($urandom);
    s.valid = ($urandom_range(7) != 0);
    s.pc    = $urandom;
    s.rd1   = $urandom;
    s.rd2   = $urandom;
    s.imm   = $urandom;
    s.rs    = AW'($urandom_range(3));
    s.rt    = AW'($urandom_range(3));
    s.rd    = AW'($urandom_range(31));
    return s;
  endfunction

  // One clock: check stall before the edge, then EX contents and count after it.
  task automatic cycle(input string tag);
    logic hz, exp_stall;
    drive();
    #1;
    hz        = model_hazard();
    exp_stall = (hz || hold) && !flush;
    chk({tag, "/stall"}, 160'(bus.stall_o), 160'(exp_stall));
    @(posedge clk);
    if (flush || (!hold && hz)) begin
      exp_s   = '0;
      exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
    end else if (!hold) begin
      exp_s = in_s;
    end
    #1;
    chk({tag, "/ex"}, 160'(observed()), 160'(exp_s));
    chk({tag, "/cnt"}, 160'(bus.bubble_cnt), 160'(exp_cnt));
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    hold    = 1'b0;
    in_s    = '0;
    exp_s   = '0;
    exp_cnt = 0;
    drive();
    #2;
    chk("reset/ex", 160'(observed()), 160'(exp_s));
    chk("reset/cnt", 160'(bus.bubble_cnt), 160'(0));
    chk("reset/stall", 160'(bus.stall_o), 160'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // R-type pass-through
    in_s = '0;
    in_s.wb = 2'b10; in_s.m = 3'b000; in_s.ex = 2'b10; in_s.alu = 2'b10;
    in_s.rs = 1; in_s.rt = 2; in_s.rd = 3; in_s.rd1 = 32'h11; in_s.valid = 1'b1;
    cycle("rtype");
    chk("rtype/valid", 160'(bus.ex_valid), 160'(1));

    // Load-use: one bubble, then the dependent add advances
    in_s = '0; in_s.valid = 1'b1; in_s.wb = 2'b11; in_s.m = 3'b010; in_s.rt = 5; in_s.rs = 8;
    cycle("lw5");
    in_s = '0; in_s.valid = 1'b1; in_s.wb = 2'b10; in_s.rs = 5; in_s.rt = 6; in_s.rd = 7;
    in_s.pc = 32'h104;
    cycle("lu_stall");
    chk("lu_stall/cnt1", 160'(bus.bubble_cnt), 160'(1));
    cycle("lu_resume");

    // $zero destination never stalls
    in_s = '0; in_s.valid = 1'b1; in_s.m = 3'b010; in_s.rt = 0; in_s.rs = 7;
    cycle("lw0");
    in_s = '0; in_s.valid = 1'b1; in_s.wb = 2'b10; in_s.rs = 0; in_s.rt = 0; in_s.rd = 9;
    cycle("zero_rs");

    // Flush with hazard present, then flush with hold
    in_s = '0; in_s.valid = 1'b1; in_s.m = 3'b010; in_s.rt = 4;
    cycle("lw4");
    in_s = '0; in_s.valid = 1'b1; in_s.rs = 4; in_s.rd = 2;
    flush = 1'b1;
    cycle("flush_hz");
    in_s = rand_instr();
    hold = 1'b1;
    cycle("flush_hold");
    flush = 1'b0;
    hold  = 1'b0;

    // Hold for three cycles while ID changes
    in_s = rand_instr(); in_s.valid = 1'b1; in_s.m = 3'b000;
    cycle("pre_hold");
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_s = rand_instr();
      cycle("hold");
    end
    hold = 1'b0;

    // Async reset in the middle of a load-use stall
    in_s = '0; in_s.valid = 1'b1; in_s.m = 3'b010; in_s.rt = 9;
    cycle("lw9");
    in_s = '0; in_s.valid = 1'b1; in_s.rs = 9;
    drive();
    #1;
    chk("midstall/stall", 160'(bus.stall_o), 160'(1));
    rst_n = 1'b0;
    #1;
    exp_s   = '0;
    exp_cnt = 0;
    chk("async_rst/ex", 160'(observed()), 160'(exp_s));
    chk("async_rst/cnt", 160'(bus.bubble_cnt), 160'(0));
    chk("async_rst/stall", 160'(bus.stall_o), 160'(0));
    #1 rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      in_s  = rand_instr();
      flush = ($urandom_range(9) == 0);
      hold  = ($urandom_range(5) == 0);
      cycle("rand");
    end

    // Counter saturation
    hold  = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_s = rand_instr();
      cycle("sat");
    end
    chk("sat/final", 160'(bus.bubble_cnt), 160'(CNT_MAX));
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
